// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } memState_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;
  localparam int         LANES    = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: store byte enables and replication, load lane extraction.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic        storeByte,
  input  logic [1:0]  storeAddrLow,
  input  logic [31:0] storeData,
  input  logic        loadByte,
  input  logic [1:0]  loadAddrLow,
  input  logic [31:0] loadData,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] loadResult
);

  always_comb begin
    be         = storeByte ? (BE_BYTE0 << storeAddrLow) : BE_WORD;
    // A byte store drives its byte on every lane; the enables pick the target.
    wdata      = storeByte ? {LANES{storeData[7:0]}} : storeData;
    loadResult = loadByte ? {24'b0, loadData[8*loadAddrLow +: 8]} : loadData;
  end

endmodule

// File: rtl/memory_access_stage.sv
// RV32 memory stage: req/ack data-memory access with upstream stall.
// Optional access timeout enabled by defining MEM_TIMEOUT_EN.
module memory_access_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  validE_i,
  input  logic                  resultSRCE_i,
  input  logic                  memWriteE_i,
  input  logic                  addrSelectE_i,
  input  logic [DATA_WIDTH-1:0] ALUresultE_i,
  input  logic [DATA_WIDTH-1:0] RD2E_i,
  output logic                  memReq_o,
  output logic                  memWe_o,
  output logic [DATA_WIDTH-1:0] memAddr_o,
  output logic [3:0]            memBe_o,
  output logic [DATA_WIDTH-1:0] memWdata_o,
  input  logic                  memAck_i,
  input  logic [DATA_WIDTH-1:0] memRdata_i,
  output logic                  stallM_o,
  output logic                  validM_o,
  output logic [DATA_WIDTH-1:0] resultM_o,
  output logic                  errM_o
);

  memState_t             state, stateNext;
  logic [DATA_WIDTH-1:0] addrQ, wdataQ, resultQ;
  logic [3:0]            beQ;
  logic                  weQ, byteQ, validQ;
  logic                  memOpE, acceptMem, passThru, finish, timedOut, timeoutHit;
  logic [3:0]            alignBe;
  logic [DATA_WIDTH-1:0] alignWdata, loadResult;

  // A store wins over a load when both flags are set.
  assign memOpE = memWriteE_i | resultSRCE_i;

  mem_lane_align u_align (
    .storeByte    (addrSelectE_i),
    .storeAddrLow (ALUresultE_i[1:0]),
    .storeData    (RD2E_i),
    .loadByte     (byteQ),
    .loadAddrLow  (addrQ[1:0]),
    .loadData     (memRdata_i),
    .be           (alignBe),
    .wdata        (alignWdata),
    .loadResult   (loadResult)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    stateNext = state;
    acceptMem = 1'b0;
    passThru  = 1'b0;
    finish    = 1'b0;
    timedOut  = 1'b0;
    case (state)
      IDLE: begin
        if (validE_i) begin
          if (memOpE) begin
            acceptMem = 1'b1;
            stateNext = REQ;
          end else begin
            passThru = 1'b1;
          end
        end
      end
      REQ: begin
        if (memAck_i) begin
          finish    = 1'b1;
          stateNext = DONE;
        end else if (timeoutHit) begin
          timedOut  = 1'b1;
          stateNext = DONE;
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state   <= IDLE;
      addrQ   <= '0;
      wdataQ  <= '0;
      beQ     <= '0;
      weQ     <= 1'b0;
      byteQ   <= 1'b0;
      resultQ <= '0;
      validQ  <= 1'b0;
    end else begin
      state  <= stateNext;
      validQ <= passThru | finish | timedOut;
      if (acceptMem) begin
        addrQ  <= ALUresultE_i;
        wdataQ <= alignWdata;
        beQ    <= alignBe;
        weQ    <= memWriteE_i;
        byteQ  <= addrSelectE_i;
      end
      if (passThru) begin
        resultQ <= ALUresultE_i;
      end else if (finish) begin
        resultQ <= weQ ? addrQ : loadResult;
      end else if (timedOut) begin
        resultQ <= '0;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CNT_W-1:0] timeoutCnt;
  logic             errQ;

  always_ff @(posedge clk) begin
    if (rst) begin
      timeoutCnt <= '0;
      errQ       <= 1'b0;
    end else begin
      errQ <= timedOut;
      if (acceptMem) begin
        timeoutCnt <= '0;
      end else if (state == REQ && !memAck_i) begin
        timeoutCnt <= timeoutCnt + CNT_W'(1);
      end
    end
  end

  // Leaving on the edge where the count reaches the limit gives exactly TIMEOUT_CYCLES REQ cycles.
  assign timeoutHit = (state == REQ) && (timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign errM_o     = errQ;
`else
  logic unusedTimeout;
  assign unusedTimeout = (TIMEOUT_CYCLES != 0);
  assign timeoutHit    = 1'b0;
  assign errM_o        = 1'b0;
`endif

  assign memReq_o   = (state == REQ);
  assign memWe_o    = weQ;
  assign memAddr_o  = {addrQ[DATA_WIDTH-1:2], 2'b00};
  assign memBe_o    = beQ;
  assign memWdata_o = wdataQ;
  assign stallM_o   = acceptMem || (state == REQ);
  assign validM_o   = validQ;
  assign resultM_o  = resultQ;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed self-checking bench for memory_access_stage.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        validE_i = 1'b0, resultSRCE_i = 1'b0, memWriteE_i = 1'b0, addrSelectE_i = 1'b0;
  logic [31:0] ALUresultE_i = '0, RD2E_i = '0, memRdata_i = '0;
  logic        memAck_i = 1'b0;
  logic        memReq_o, memWe_o, stallM_o, validM_o, errM_o;
  logic [31:0] memAddr_o, memWdata_o, resultM_o;
  logic [3:0]  memBe_o;

  int nCompared   = 0;
  int nMismatched = 0;

  always #5 clk = ~clk;

  memory_access_stage #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .validE_i(validE_i), .resultSRCE_i(resultSRCE_i),
    .memWriteE_i(memWriteE_i), .addrSelectE_i(addrSelectE_i), .ALUresultE_i(ALUresultE_i),
    .RD2E_i(RD2E_i), .memReq_o(memReq_o), .memWe_o(memWe_o), .memAddr_o(memAddr_o),
    .memBe_o(memBe_o), .memWdata_o(memWdata_o), .memAck_i(memAck_i), .memRdata_i(memRdata_i),
    .stallM_o(stallM_o), .validM_o(validM_o), .resultM_o(resultM_o), .errM_o(errM_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic ld, input logic st, input logic bt,
                       input logic [31:0] alu, input logic [31:0] rd2);
    validE_i = v; resultSRCE_i = ld; memWriteE_i = st; addrSelectE_i = bt;
    ALUresultE_i = alu; RD2E_i = rd2;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    nCompared++;
    if ({memReq_o, memWe_o, stallM_o, validM_o, errM_o, memBe_o} !== 9'b0) begin
      nMismatched++;
      $display("FAIL reset_ctrl: got req=%b we=%b stall=%b valid=%b err=%b be=%h, want all 0",
               memReq_o, memWe_o, stallM_o, validM_o, errM_o, memBe_o);
    end
    nCompared++;
    if ({memAddr_o, memWdata_o, resultM_o} !== 96'b0) begin
      nMismatched++;
      $display("FAIL reset_data: got addr=%h wdata=%h result=%h, want 0", memAddr_o, memWdata_o, resultM_o);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1234, 32'h0);
    nCompared++;
    if (stallM_o !== 1'b0) begin
      nMismatched++; $display("FAIL pass_stall_accept: got %b want 0", stallM_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++;
    if ({validM_o, resultM_o, stallM_o, memReq_o} !== {1'b1, 32'h0000_1234, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("FAIL pass_result: got valid=%b result=%h stall=%b req=%b want 1/00001234/0/0",
               validM_o, resultM_o, stallM_o, memReq_o);
    end
    tick();
    nCompared++;
    if (validM_o !== 1'b0) begin
      nMismatched++; $display("FAIL pass_single_pulse: got validM=%b want 0", validM_o);
    end
  endtask

  task automatic test_word_load();
    int stallCycles;
    stallCycles = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'hFFFF_FFFF);
    if (stallM_o) stallCycles++;
    tick();
    nCompared++;
    if ({memReq_o, memWe_o, memAddr_o, memBe_o, validM_o} !== {1'b1, 1'b0, 32'h100, 4'hF, 1'b0}) begin
      nMismatched++;
      $display("FAIL wload_req: got req=%b we=%b addr=%h be=%h valid=%b want 1/0/00000100/f/0",
               memReq_o, memWe_o, memAddr_o, memBe_o, validM_o);
    end
    if (stallM_o) stallCycles++;
    tick();
    memAck_i = 1'b1; memRdata_i = 32'hDEAD_BEEF;
    #1;
    if (stallM_o) stallCycles++;
    tick();
    memAck_i = 1'b0; memRdata_i = 32'h0;
    if (stallM_o) stallCycles++;
    nCompared++;
    if (stallCycles !== 3) begin
      nMismatched++; $display("FAIL wload_stall_len: got %0d cycles want 3", stallCycles);
    end
    nCompared++;
    if ({validM_o, resultM_o, memReq_o, errM_o} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0}) begin
      nMismatched++;
      $display("FAIL wload_done: got valid=%b result=%h req=%b err=%b want 1/deadbeef/0/0",
               validM_o, resultM_o, memReq_o, errM_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    nCompared++;
    if ({validM_o, stallM_o, memReq_o} !== 3'b000) begin
      nMismatched++;
      $display("FAIL wload_idle: got valid=%b stall=%b req=%b want 0/0/0", validM_o, stallM_o, memReq_o);
    end
  endtask

  task automatic test_byte_store();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 32'hABCD_EF55);
    tick();
    nCompared++;
    if ({memReq_o, memWe_o, memBe_o, memWdata_o, memAddr_o} !== {1'b1, 1'b1, 4'b1000, 32'h5555_5555, 32'h100}) begin
      nMismatched++;
      $display("FAIL bstore_req: got req=%b we=%b be=%b wdata=%h addr=%h want 1/1/1000/55555555/00000100",
               memReq_o, memWe_o, memBe_o, memWdata_o, memAddr_o);
    end
    memAck_i = 1'b1; memRdata_i = 32'h1111_1111;
    tick();
    memAck_i = 1'b0; memRdata_i = 32'h0;
    nCompared++;
    if ({validM_o, resultM_o, stallM_o} !== {1'b1, 32'h0000_0103, 1'b0}) begin
      nMismatched++;
      $display("FAIL bstore_done: got valid=%b result=%h stall=%b want 1/00000103/0", validM_o, resultM_o, stallM_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_byte_load();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0102, 32'h0);
    tick();
    nCompared++;
    if ({memReq_o, memWe_o, memBe_o, memAddr_o} !== {1'b1, 1'b0, 4'b0100, 32'h100}) begin
      nMismatched++;
      $display("FAIL bload_req: got req=%b we=%b be=%b addr=%h want 1/0/0100/00000100",
               memReq_o, memWe_o, memBe_o, memAddr_o);
    end
    memAck_i = 1'b1; memRdata_i = 32'hAABB_CCDD;
    tick();
    memAck_i = 1'b0; memRdata_i = 32'h0;
    nCompared++;
    if ({validM_o, resultM_o} !== {1'b1, 32'h0000_00BB}) begin
      nMismatched++;
      $display("FAIL bload_done: got valid=%b result=%h want 1/000000bb", validM_o, resultM_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_stray_ack();
    memAck_i = 1'b1; memRdata_i = 32'h1234_5678;
    tick();
    memAck_i = 1'b0;
    tick();
    nCompared++;
    if ({validM_o, memReq_o, stallM_o} !== 3'b000) begin
      nMismatched++;
      $display("FAIL stray_ack: got valid=%b req=%b stall=%b want 0/0/0", validM_o, memReq_o, stallM_o);
    end
  endtask

  task automatic test_reset_in_req();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0);
    tick();
    tick();
    nCompared++;
    if (memReq_o !== 1'b1) begin
      nMismatched++; $display("FAIL rstreq_pre: got req=%b want 1", memReq_o);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    memAck_i = 1'b1; memRdata_i = 32'hCAFE_F00D;
    nCompared++;
    if ({memReq_o, stallM_o, validM_o} !== 3'b000) begin
      nMismatched++;
      $display("FAIL rstreq_drop: got req=%b stall=%b valid=%b want 0/0/0", memReq_o, stallM_o, validM_o);
    end
    tick();
    memAck_i = 1'b0; memRdata_i = 32'h0;
    nCompared++;
    if ({validM_o, memReq_o, resultM_o} !== {1'b0, 1'b0, 32'h0}) begin
      nMismatched++;
      $display("FAIL rstreq_late_ack: got valid=%b req=%b result=%h want 0/0/00000000",
               validM_o, memReq_o, resultM_o);
    end
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00AA, 32'h0);
    tick();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_00BB, 32'h0);
    nCompared++;
    if ({validM_o, resultM_o, stallM_o} !== {1'b1, 32'h0000_00AA, 1'b0}) begin
      nMismatched++;
      $display("FAIL b2b_first: got valid=%b result=%h stall=%b want 1/000000aa/0", validM_o, resultM_o, stallM_o);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nCompared++;
    if ({validM_o, resultM_o} !== {1'b1, 32'h0000_00BB}) begin
      nMismatched++;
      $display("FAIL b2b_second: got valid=%b result=%h want 1/000000bb", validM_o, resultM_o);
    end
    tick();
  endtask

`ifdef MEM_TIMEOUT_EN
  task automatic test_timeout();
    int reqCycles;
    reqCycles = 0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0300, 32'h0);
    for (int i = 0; i < 8 && !validM_o; i++) begin
      tick();
      if (memReq_o) reqCycles++;
    end
    nCompared++;
    if (reqCycles !== 4) begin
      nMismatched++; $display("FAIL timeout_len: got %0d REQ cycles want 4", reqCycles);
    end
    nCompared++;
    if ({validM_o, errM_o, resultM_o, memReq_o} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
      nMismatched++;
      $display("FAIL timeout_done: got valid=%b err=%b result=%h req=%b want 1/1/00000000/0",
               validM_o, errM_o, resultM_o, memReq_o);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    tick();
    nCompared++;
    if ({validM_o, errM_o} !== 2'b00) begin
      nMismatched++; $display("FAIL timeout_pulse: got valid=%b err=%b want 0/0", validM_o, errM_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_word_load();
    test_byte_store();
    test_byte_load();
    test_stray_ack();
    test_reset_in_req();
    test_back_to_back();
`ifdef MEM_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
# memory_access_stage

Memory stage of the pipelined RV32 core: consumes the control and data fields registered at the end of execute and performs the data-memory access through a req/ack handshake with variable latency. While an access is outstanding it stalls the upstream pipeline, then presents one result per instruction to writeback. Non-memory instructions pass through in one cycle.

## Interface
- DATA_WIDTH, 32, datapath width; byte-lane logic is fixed at 4 lanes, so only 32 is supported
- TIMEOUT_CYCLES, 255, maximum cycles in REQ before abort; used only when MEM_TIMEOUT_EN is defined
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- validE_i  in  1  instruction present in the stage
- resultSRCE_i  in  1  1 = load (result from memory), 0 = ALU result
- memWriteE_i  in  1  store; has priority over resultSRCE_i
- addrSelectE_i  in  1  1 = byte access, 0 = word access
- ALUresultE_i  in  DATA_WIDTH  address, or pass-through result
- RD2E_i  in  DATA_WIDTH  store data
- memReq_o  out  1  access request
- memWe_o  out  1  write enable
- memAddr_o  out  DATA_WIDTH  word-aligned address, {ALU[31:2],2'b00}
- memBe_o  out  4  byte enables
- memWdata_o  out  DATA_WIDTH  store data
- memAck_i  in  1  access complete; memRdata_i valid the same cycle for loads
- memRdata_i  in  DATA_WIDTH  read data
- stallM_o  out  1  upstream holds all *E_i inputs while high
- validM_o  out  1  one-cycle pulse per retired instruction
- resultM_o  out  DATA_WIDTH  writeback value
- errM_o  out  1  access timed out; tied 0 without MEM_TIMEOUT_EN

## Operation
- FSM states: IDLE, REQ, DONE.
- IDLE, validE_i=1, no memory op: resultM_o<=ALUresultE_i, validM_o<=1 next cycle; state stays IDLE; no stall.
- IDLE, validE_i=1, memory op: latch address, write enable, byte enables and write data; go to REQ. stallM_o=1 combinationally this cycle.
- REQ: memReq_o=1 with latched fields held stable; stallM_o=1. On memAck_i: a load captures its lane-extracted data into resultM_o, a store loads ALU address into resultM_o; go to DONE.
- DONE: validM_o=1, stallM_o=0; upstream advances; go to IDLE. An instruction presented in DONE is not accepted until IDLE.
- Byte access: memBe_o = 4'b0001 << ALU[1:0]; memWdata_o = {4{RD2[7:0]}}; load result = zero-extended byte memRdata_i[8*ALU[1:0]+:8].
- Word access: memBe_o=4'b1111; ALU[1:0] ignored; data unmodified.
- memWriteE_i=1 together with resultSRCE_i=1 is treated as a store.
- memAck_i outside REQ is ignored.

## Timing
- Reset: state IDLE; memReq_o, memWe_o, stallM_o, validM_o, errM_o = 0; memAddr_o, memWdata_o, resultM_o = 0; memBe_o=0.
- Pass-through latency: 1 cycle.
- Memory op latency: accept (cycle 0), REQ from cycle 1, DONE the cycle after the ack edge. Minimum is 3 cycles with ack in the first REQ cycle.
- rst during REQ: memReq_o drops on that edge and the access is abandoned; a later ack is ignored.
- validM_o never asserts on two consecutive cycles for the same instruction.

## Configuration
- MEM_TIMEOUT_EN defined: an 8+ bit counter clears on REQ entry and increments each REQ cycle without ack. When it reaches TIMEOUT_CYCLES, memReq_o drops, the FSM goes to DONE with resultM_o=0 and errM_o=1. errM_o is a one-cycle pulse coincident with validM_o.
- MEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; errM_o constant 0.

## Structure
- mem_stage_pkg: state enum (IDLE/REQ/DONE), BE_WORD=4'b1111, BE_BYTE0=4'b0001, lane count constant.
- Sub-module mem_lane_align (combinational): byte-enable generation, store replication, load lane extraction.

## Test plan
- ADD pass-through: ALUresultE=0x0000_1234, validE=1 -> next cycle validM=1, resultM=0x1234, stallM never high.
- Word load at 0x100, ack after 2 REQ cycles, rdata=0xDEADBEEF -> memAddr=0x100, memBe=0xF, stallM high for 3 cycles, then validM=1, resultM=0xDEADBEEF.
- Byte store at 0x103, RD2=0x55 -> memWe=1, memBe=4'b1000, memWdata=0x55555555, memAddr=0x100.
- Byte load at 0x102, rdata=0xAABBCCDD -> resultM=0x000000BB.
- rst asserted in second REQ cycle, ack one cycle later -> memReq=0 after the reset edge, no validM, state IDLE.
- MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> memReq drops after 4 REQ cycles; validM=1, errM=1, resultM=0.
